cpu_jtag_debug_sysclk_bridge: RTL and testbench

System-clock-side partner of the TCK-domain JTAG debug shift logic.
- Synchronises the TCK-domain update-IR and update-DR indications into clk.
- Captures the instruction register and the 38-bit shift register contents.
- Decodes them into single-cycle action strobes for the on-chip memory, break and trace controllers of the CPU debug module.
- It is the only path by which host JTAG commands reach clk-domain logic.

---
 rtl/cpu_jtag_debug_pkg.sv | 71 +++++++
 rtl/jtag_level_sync_edge.sv | 42 ++++
 rtl/cpu_jtag_debug_sysclk_bridge.sv | 81 ++++++++
 tb/tb_cpu_jtag_debug_sysclk_bridge.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cpu_jtag_debug_pkg.sv
// Shared constants for the clk-side JTAG debug bridge: action strobe bit map, IR codes, jdo fields.
// Also holds the pure decode from (ir, selected jdo bits) to action strobes.
package cpu_jtag_debug_pkg;

  localparam int TA_W = 13;

  localparam int TA_OCIMEM_A        = 0;
  localparam int TA_NOACT_OCIMEM_A  = 1;
  localparam int TA_OCIMEM_B        = 2;
  localparam int TA_TRACEMEM_A      = 3;
  localparam int TA_NOACT_TRACEMEM_A = 4;
  localparam int TA_TRACEMEM_B      = 5;
  localparam int TA_BREAK_A         = 6;
  localparam int TA_NOACT_BREAK_A   = 7;
  localparam int TA_BREAK_B         = 8;
  localparam int TA_NOACT_BREAK_B   = 9;
  localparam int TA_BREAK_C         = 10;
  localparam int TA_NOACT_BREAK_C   = 11;
  localparam int TA_TRACECTRL       = 12;

  typedef enum logic [1:0] {
    IR_OCIMEM    = 2'b00,
    IR_TRACEMEM  = 2'b01,
    IR_BREAK     = 2'b10,
    IR_TRACECTRL = 2'b11
  } ir_code_e;

  localparam int JDO_B15 = 15;
  localparam int JDO_B34 = 34;
  localparam int JDO_B35 = 35;
  localparam int JDO_B36 = 36;
  localparam int JDO_B37 = 37;

  typedef struct packed {
    logic b37;
    logic b36;
    logic b35;
    logic b34;
    logic b15;
  } jdo_sel_t;

  function automatic logic [TA_W-1:0] decode_action(ir_code_e ir, jdo_sel_t d);
    logic [TA_W-1:0] ta;
    ta = '0;
    case (ir)
      IR_OCIMEM: begin
        ta[TA_OCIMEM_A]       = !d.b35 &  d.b34;
        ta[TA_NOACT_OCIMEM_A] = !d.b35 & !d.b34;
        ta[TA_OCIMEM_B]       =  d.b35;
      end
      IR_TRACEMEM: begin
        ta[TA_TRACEMEM_A]       = !d.b37 &  d.b36;
        ta[TA_NOACT_TRACEMEM_A] = !d.b37 & !d.b36;
        ta[TA_TRACEMEM_B]       =  d.b37;
      end
      IR_BREAK: begin
        ta[TA_BREAK_A]       =  d.b37 & !d.b36;
        ta[TA_NOACT_BREAK_A] = !d.b37 & !d.b36;
        ta[TA_BREAK_B]       =  d.b37 &  d.b36 & !d.b35;
        ta[TA_NOACT_BREAK_B] = !d.b37 &  d.b36 & !d.b35;
        ta[TA_BREAK_C]       =  d.b37 &  d.b36 &  d.b35;
        ta[TA_NOACT_BREAK_C] = !d.b37 &  d.b36 &  d.b35;
      end
      default: begin
        ta[TA_TRACECTRL] = d.b15;
      end
    endcase
    return ta;
  endfunction

endpackage

// File: rtl/jtag_level_sync_edge.sv
// Synchronises a slow TCK-domain level into clk and emits a one-cycle rise indication.
// Rise is combinational from SYNC_STAGES+1 flops; no backpressure.
module jtag_level_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   dly_q;
  logic                   armed_q;
  logic                   sync_lvl;
  logic                   filled;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign filled   = fill_q[SYNC_STAGES-1];

  // fill_q marks when the synchroniser holds real samples rather than reset zeros,
  // so a level already high at reset release can never arm and fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      dly_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      dly_q  <= sync_lvl;
      if (filled && !sync_lvl) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise_o = sync_lvl & ~dly_q & armed_q;

endmodule

// File: rtl/cpu_jtag_debug_sysclk_bridge.sv
// clk-side partner of the TCK debug shift logic: captures ir/sr on update events and decodes action strobes.
// take_action rises SYNC_STAGES+1 edges after vs_udr is first sampled high; no backpressure.
module cpu_jtag_debug_sysclk_bridge
  import cpu_jtag_debug_pkg::*;
#(
  parameter int SR_W        = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SR_W-1:0] sr,
  input  logic [1:0]      ir_in,
  input  logic            vs_udr,
  input  logic            vs_uir,
  output logic [SR_W-1:0] jdo,
  output logic [1:0]      ir,
  output logic            jxuir,
  output logic [TA_W-1:0] take_action
);

  logic            udr_rise;
  logic            uir_rise;
  logic [SR_W-1:0] jdo_q;
  logic [1:0]      ir_q;
  logic            jxuir_q;
  logic            en_strobe_q;
  logic [TA_W-1:0] ta_q;
  logic [TA_W-1:0] ta_d;
  jdo_sel_t        jdo_sel;

  jtag_level_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset   (reset),
    .level_i (vs_udr),
    .rise_o  (udr_rise)
  );

  jtag_level_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset   (reset),
    .level_i (vs_uir),
    .rise_o  (uir_rise)
  );

  assign jdo_sel = '{b37: jdo_q[JDO_B37], b36: jdo_q[JDO_B36], b35: jdo_q[JDO_B35],
                     b34: jdo_q[JDO_B34], b15: jdo_q[JDO_B15]};

  // Decode runs one cycle after capture so a simultaneous uir update is already in ir_q.
  always_comb begin
    ta_d = '0;
    if (en_strobe_q) begin
      ta_d = decode_action(ir_code_e'(ir_q), jdo_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_q       <= '0;
      ir_q        <= '0;
      jxuir_q     <= 1'b0;
      en_strobe_q <= 1'b0;
      ta_q        <= '0;
    end else begin
      if (udr_rise) begin
        jdo_q <= sr;
      end
      if (uir_rise) begin
        ir_q <= ir_in;
      end
      jxuir_q     <= uir_rise;
      en_strobe_q <= udr_rise;
      ta_q        <= ta_d;
    end
  end

  assign jdo         = jdo_q;
  assign ir          = ir_q;
  assign jxuir       = jxuir_q;
  assign take_action = ta_q;

endmodule

// File: tb/tb_cpu_jtag_debug_sysclk_bridge.sv
// Directed bench for cpu_jtag_debug_sysclk_bridge with hand-computed strobe vectors.
module tb_cpu_jtag_debug_sysclk_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr;
  logic        vs_uir;
  logic [37:0] jdo;
  logic [1:0]  ir;
  logic        jxuir;
  logic [12:0] take_action;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_jtag_debug_sysclk_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .sr          (sr),
    .ir_in       (ir_in),
    .vs_udr      (vs_udr),
    .vs_uir      (vs_uir),
    .jdo         (jdo),
    .ir          (ir),
    .jxuir       (jxuir),
    .take_action (take_action)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises the selected update levels for 'hold' edges and records strobe/pulse timing.
  // k counts edges from the first one that samples the level high.
  task automatic run_event(input logic do_udr, input logic do_uir, input logic [37:0] s,
                           input logic [1:0] irv, input int hold,
                           output int ta_first, output int ta_cnt, output logic [12:0] ta_val,
                           output int jx_first, output int jx_cnt);
    ta_first = -1; ta_cnt = 0; ta_val = '0; jx_first = -1; jx_cnt = 0;
    sr = s; ir_in = irv; vs_udr = do_udr; vs_uir = do_uir;
    for (int k = 1; k <= hold + 6; k++) begin
      tick();
      if (k == hold) begin
        vs_udr = 1'b0;
        vs_uir = 1'b0;
      end
      if (take_action != 0) begin
        ta_cnt++;
        if (ta_first < 0) begin
          ta_first = k;
          ta_val   = take_action;
        end
      end
      if (jxuir) begin
        jx_cnt++;
        if (jx_first < 0) jx_first = k;
      end
    end
  endtask

  initial begin
    int tf, tc, jf, jc, quiet;
    logic [12:0] tv;

    reset = 1'b1; sr = '0; ir_in = 2'b00; vs_udr = 1'b0; vs_uir = 1'b0;
    repeat (3) tick();
    chk("rst_jdo", 64'(jdo), 64'h0);
    chk("rst_ir", 64'(ir), 64'h0);
    chk("rst_jxuir", 64'(jxuir), 64'h0);
    chk("rst_ta", 64'(take_action), 64'h0);
    reset = 1'b0;
    repeat (5) tick();

    run_event(1'b0, 1'b1, 38'h0, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("uir00_jx_first", 64'(jf), 64'd3);
    chk("uir00_jx_cnt", 64'(jc), 64'd1);
    chk("uir00_ir", 64'(ir), 64'h0);
    run_event(1'b1, 1'b0, 38'h04_1234_5678, 2'b00, 5, tf, tc, tv, jf, jc);
    chk("ocim_jdo", 64'(jdo), 64'h04_1234_5678);
    chk("ocim_val", 64'(tv), 64'h0001);
    chk("ocim_first", 64'(tf), 64'd4);
    chk("ocim_cnt", 64'(tc), 64'd1);

    run_event(1'b0, 1'b1, 38'h0, 2'b10, 4, tf, tc, tv, jf, jc);
    chk("uir10_ir", 64'(ir), 64'h2);
    run_event(1'b1, 1'b0, 38'h38_0000_00AA, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("brk_c_val", 64'(tv), 64'h0400);
    chk("brk_c_cnt", 64'(tc), 64'd1);
    run_event(1'b1, 1'b0, 38'h18_0000_0000, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("nobrk_c_val", 64'(tv), 64'h0800);
    chk("nobrk_c_cnt", 64'(tc), 64'd1);
    run_event(1'b1, 1'b0, 38'h20_0000_0001, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("brk_a_val", 64'(tv), 64'h0040);
    chk("brk_a_cnt", 64'(tc), 64'd1);

    run_event(1'b0, 1'b1, 38'h0, 2'b11, 4, tf, tc, tv, jf, jc);
    chk("uir11_ir", 64'(ir), 64'h3);
    run_event(1'b1, 1'b0, 38'h00_0000_8000, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("tctrl_val", 64'(tv), 64'h1000);
    chk("tctrl_cnt", 64'(tc), 64'd1);
    run_event(1'b1, 1'b0, 38'h3F_FFFF_7FFF, 2'b00, 4, tf, tc, tv, jf, jc);
    chk("tctrl0_cnt", 64'(tc), 64'd0);
    chk("tctrl0_jdo", 64'(jdo), 64'h3F_FFFF_7FFF);

    run_event(1'b1, 1'b0, 38'h00_0000_8001, 2'b00, 20, tf, tc, tv, jf, jc);
    chk("hold20_cnt", 64'(tc), 64'd1);
    chk("hold20_first", 64'(tf), 64'd4);
    sr = 38'h2A_AAAA_AAAA; ir_in = 2'b01;
    repeat (6) tick();
    chk("hold_jdo", 64'(jdo), 64'h00_0000_8001);
    chk("hold_ir", 64'(ir), 64'h3);

    sr = 38'h04_0000_0001; ir_in = 2'b00; vs_udr = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("midrst_ta", 64'(take_action), 64'h0);
    chk("midrst_jdo", 64'(jdo), 64'h0);
    tick();
    chk("midrst_ta2", 64'(take_action), 64'h0);
    chk("midrst_ir", 64'(ir), 64'h0);
    reset = 1'b0;
    quiet = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (take_action != 0) quiet++;
    end
    chk("rst_high_nostrobe", 64'(quiet), 64'd0);
    vs_udr = 1'b0;
    repeat (3) tick();
    run_event(1'b1, 1'b0, 38'h04_0000_0001, 2'b00, 5, tf, tc, tv, jf, jc);
    chk("rearm_val", 64'(tv), 64'h0001);
    chk("rearm_cnt", 64'(tc), 64'd1);

    run_event(1'b1, 1'b1, 38'h10_0000_0000, 2'b01, 5, tf, tc, tv, jf, jc);
    chk("both_ir", 64'(ir), 64'h1);
    chk("both_val", 64'(tv), 64'h0008);
    chk("both_first", 64'(tf), 64'd4);
    chk("both_cnt", 64'(tc), 64'd1);
    chk("both_jx_cnt", 64'(jc), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
